multiplicador_seq: RTL and testbench

- Sequential shift-and-add unsigned multiplier for the 8-bit ALU.
- Performs the inverse operation of the combinational divider path: product = data0_i × data1_i.
- Computes one multiplier bit per clock, so the ALU needs no wide combinational multiplier.
- Uses a start/busy/done handshake; the full-width product is held stable for the ALU result mux until the next operation completes.

---
 rtl/multiplicador_seq.sv | 153 +++++++++++++++
 tb/tb_multiplicador_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_seq.sv
// -----------------------------------------------------------------------------
// multiplicador_seq
//
// Sequential shift-and-add unsigned multiplier for the 8-bit ALU. It retires
// one multiplier bit per clock, so the ALU can form a full 2*WIDTH product
// without a wide combinational multiplier.
//
// Handshake: start_i is accepted in IDLE or DONE. The unit then spends
// exactly WIDTH cycles in RUN (busy_o=1) and one cycle in DONE (done_o=1).
// result_o/overflow_o are loaded only on the edge that enters DONE and are
// held for the ALU result mux until the next completion or a reset.
//
// Ports:
//   clk_i      in   1        system clock, rising edge
//   rst_ni     in   1        synchronous reset, active-low
//   start_i    in   1        multiply request, accepted in IDLE/DONE
//   data0_i    in   WIDTH    multiplicand (unsigned), captured on accept
//   data1_i    in   WIDTH    multiplier (unsigned), captured on accept
//   busy_o     out  1        high while iterating (RUN)
//   done_o     out  1        one-cycle pulse: result_o holds a new product
//   result_o   out  2*WIDTH  unsigned product, held between completions
//   overflow_o out  1        upper half of result_o is non-zero
// -----------------------------------------------------------------------------
module multiplicador_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data0_i,
    input  logic [WIDTH-1:0]   data1_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               overflow_o
);

    // Counter only has to reach WIDTH-1; the final iteration is detected
    // before the increment would wrap.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [2*WIDTH-1:0]   r_mcand;    // multiplicand, shifted left each iteration
    logic [WIDTH-1:0]     r_mplier;   // multiplier, shifted right each iteration
    logic [2*WIDTH-1:0]   r_acc;      // running partial product
    logic [CW-1:0]        r_count;    // iterations already performed
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_overflow;

    logic                 w_accept;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;

    // A new operation can start from IDLE or straight out of DONE, which
    // gives back-to-back throughput of one product every WIDTH+1 cycles.
    assign w_accept   = start_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_state == RUN) && (r_count == LAST_ITER);

    // The accumulator is 2*WIDTH bits wide, so this add never carries out:
    // (2^W-1)^2 < 2^(2W).
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking (<=) assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches whatever path the case takes.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = RUN;
            RUN:     if (w_last)   w_next_state = DONE;
            DONE:    w_next_state = w_accept ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (Moore, so busy_o and done_o can never overlap)
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            RUN:     busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: every datapath register is reset here, not just the control state,
    // because an aborted operation must leave result_o/overflow_o at zero and
    // no stale partial product may be observable afterwards.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            // Operands are latched here; the input pins are don't-care from
            // now on. result_o is deliberately left untouched.
            r_mcand  <= {{WIDTH{1'b0}}, data0_i};
            r_mplier <= data1_i;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
                // Take the sum being formed on this edge, not r_acc, so the
                // last multiplier bit is included.
                r_result   <= w_acc_next;
                r_overflow <= |w_acc_next[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign result_o   = r_result;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_multiplicador_seq.sv
// -----------------------------------------------------------------------------
// tb_multiplicador_seq
//
// Directed bench for multiplicador_seq (WIDTH=8). Stimulus pushes the
// hand-computed product into a scoreboard queue; an independent monitor pops
// and compares on every done_o pulse. Handshake timing (latency, busy length,
// hold behaviour, reset) is checked in the stimulus process.
// -----------------------------------------------------------------------------
module tb_multiplicador_seq;

    localparam int W = 8;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           start_i;
    logic [W-1:0]   data0_i;
    logic [W-1:0]   data1_i;
    logic           busy_o;
    logic           done_o;
    logic [2*W-1:0] result_o;
    logic           overflow_o;

    typedef struct packed {
        logic [2*W-1:0] res;
        logic           ov;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    multiplicador_seq #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .data0_i    (data0_i),
        .data1_i    (data1_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [2*W-1:0] res, input logic ov);
        exp_t e;
        e.res = res;
        e.ov  = ov;
        sb.push_back(e);
    endtask

    // Monitor: all outputs sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (busy_o && done_o) begin
                check("busy_done_overlap", {30'd0, busy_o, done_o}, 32'd1);
            end
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", {16'd0, result_o}, {16'd0, e.res});
                    check("overflow", {31'd0, overflow_o}, {31'd0, e.ov});
                end
            end
        end
    end

    // Called at the falling edge right after the accept edge (edges=0).
    // Returns the number of edges after the accept edge at which done_o is
    // first seen, and how many sampled cycles had busy_o high.
    task automatic wait_done(input bit noisy, output int edges, output int busy_n);
        edges  = 0;
        busy_n = 0;
        while (!done_o && edges < 40) begin
            if (busy_o) busy_n++;
            if (noisy) begin
                start_i = 1'b1;
                data0_i = 8'd99 + 8'(edges);
                data1_i = 8'($urandom);
            end
            @(negedge clk_i);
            edges++;
        end
        if (!done_o) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] exp_res, input logic exp_ov,
                      input bit noisy);
        int edges;
        int busy_n;
        @(negedge clk_i);
        start_i = 1'b1;
        data0_i = a;
        data1_i = b;
        push_exp(exp_res, exp_ov);
        @(negedge clk_i);           // accept edge has just happened
        start_i = 1'b0;
        data0_i = 8'($urandom);
        data1_i = 8'($urandom);
        wait_done(noisy, edges, busy_n);
        start_i = 1'b0;             // leave DONE back to IDLE
        check("latency_edges", edges, 8);
        check("busy_cycles", busy_n, 8);
    endtask

    initial begin
        int e1;
        int e2;
        int b1;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        data0_i = '0;
        data1_i = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_done", {31'd0, done_o}, 0);
        check("rst_result", {16'd0, result_o}, 0);
        check("rst_overflow", {31'd0, overflow_o}, 0);
        rst_ni = 1'b1;

        // Basic product and boundary operands
        op(8'd13,  8'd11,  16'd143,   1'b0, 1'b0);
        op(8'd255, 8'd255, 16'hFE01,  1'b1, 1'b0);
        op(8'd16,  8'd16,  16'd256,   1'b1, 1'b0);
        op(8'd15,  8'd17,  16'd255,   1'b0, 1'b0);
        op(8'd0,   8'd200, 16'd0,     1'b0, 1'b0);
        op(8'd1,   8'd255, 16'd255,   1'b0, 1'b0);
        op(8'd128, 8'd2,   16'd256,   1'b1, 1'b0);

        // Busy protection: start_i held with changing operands during RUN
        op(8'd6, 8'd7, 16'd42, 1'b0, 1'b1);
        repeat (12) @(negedge clk_i);
        check("no_relaunch_busy", {31'd0, busy_o}, 0);
        check("hold_after_idle", {16'd0, result_o}, 42);

        // Back-to-back: start_i held high across the DONE cycle
        @(negedge clk_i);
        start_i = 1'b1;
        data0_i = 8'd3;
        data1_i = 8'd4;
        push_exp(16'd12, 1'b0);
        @(negedge clk_i);
        data0_i = 8'd5;              // ignored in RUN, accepted at DONE
        data1_i = 8'd6;
        wait_done(1'b0, e1, b1);
        check("b2b_latency1", e1, 8);
        push_exp(16'd30, 1'b0);      // 5x6 accepted on the edge leaving DONE
        @(negedge clk_i);
        start_i = 1'b0;
        data0_i = 8'd77;
        data1_i = 8'd77;
        repeat (3) @(negedge clk_i);
        check("b2b_busy_second", {31'd0, busy_o}, 1);
        check("b2b_hold_result", {16'd0, result_o}, 12);
        wait_done(1'b0, e2, b1);
        check("b2b_done_spacing", 1 + 3 + e2, 9);

        // Reset in the 4th RUN cycle of 200x3
        @(negedge clk_i);
        start_i = 1'b1;
        data0_i = 8'd200;
        data1_i = 8'd3;
        @(negedge clk_i);            // RUN cycle 1
        start_i = 1'b0;
        repeat (3) @(negedge clk_i); // RUN cycle 4
        check("pre_abort_busy", {31'd0, busy_o}, 1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("abort_busy", {31'd0, busy_o}, 0);
        check("abort_done", {31'd0, done_o}, 0);
        check("abort_result", {16'd0, result_o}, 0);
        check("abort_overflow", {31'd0, overflow_o}, 0);

        // Reset together with start_i: must stay in IDLE
        start_i = 1'b1;
        data0_i = 8'd9;
        data1_i = 8'd9;
        @(negedge clk_i);
        check("rst_start_busy", {31'd0, busy_o}, 0);
        check("rst_start_result", {16'd0, result_o}, 0);
        start_i = 1'b0;
        rst_ni  = 1'b1;
        repeat (12) @(negedge clk_i);
        check("post_abort_idle", {31'd0, busy_o}, 0);

        // Unit still works after the abort
        op(8'd7, 8'd9, 16'd63, 1'b0, 1'b0);

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
